// File: rtl/arch_pkg.sv
// Shared types and constants for the issue scoreboard.
package arch_pkg;

  localparam int ARCH_REG_AW = 5;

  localparam logic [ARCH_REG_AW-1:0] REG_ZERO = '0;
  localparam logic [2:0]             FWD_RF   = 3'd0;

  typedef struct packed {
    logic                   valid;
    logic [ARCH_REG_AW-1:0] wd;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Matches one source operand against the in-flight entries and reports the
// youngest pending writer among entries 0..DEPTH-2.
module sb_match
  import arch_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = ARCH_REG_AW
) (
  input  logic [REG_AW-1:0]     addr,
  input  logic                  require,
  input  sb_entry_t [DEPTH-1:0] entries,
  output logic                  hit,
  output logic [2:0]            idx
);

  // Scan oldest-to-youngest so the lowest matching index is the one left behind.
  // Entry DEPTH-1 is excluded: the register file write-through covers it.
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      if (require && (addr != REG_ZERO) && entries[i].valid && (entries[i].wd == addr)) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Register-dependency scoreboard between decode and the DEPTH-stage back end.
// Optional forwarding selects are compiled in with `define ISSUE_SB_FWD_EN.
module issue_scoreboard
  import arch_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = ARCH_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] rs,
  input  logic              require_rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              require_rt,
  input  logic [REG_AW-1:0] wd,
  input  logic              reg_write,
  input  logic              flush,
  output logic [2:0]        fwd_rs_sel,
  output logic [2:0]        fwd_rt_sel,
  output logic [31:0]       stall_cycles
);

  // Handshake: an instruction issues on a cycle where dec_valid && dec_ready.
  // dec_ready depends only on the tracked entries and the presented sources,
  // never on dec_valid; decode must hold its fields stable while stalled.

  sb_entry_t [DEPTH-1:0] entries;
  sb_entry_t [DEPTH-1:0] entries_next;

  logic       rs_hit, rt_hit;
  logic [2:0] rs_idx, rt_idx;
  logic       hazard;
  logic       issue;

  sb_match #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_match_rs (
    .addr    (rs),
    .require (require_rs),
    .entries (entries),
    .hit     (rs_hit),
    .idx     (rs_idx)
  );

  sb_match #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_match_rt (
    .addr    (rt),
    .require (require_rt),
    .entries (entries),
    .hit     (rt_hit),
    .idx     (rt_idx)
  );

`ifdef ISSUE_SB_FWD_EN
  // Only entry 0 (EX) has no result yet; older matches are forwarded from stage idx.
  always_comb begin
    hazard     = (rs_hit && (rs_idx == 3'd0)) || (rt_hit && (rt_idx == 3'd0));
    fwd_rs_sel = (rs_hit && (rs_idx != 3'd0)) ? rs_idx + 3'd1 : FWD_RF;
    fwd_rt_sel = (rt_hit && (rt_idx != 3'd0)) ? rt_idx + 3'd1 : FWD_RF;
  end
`else
  logic unused_idx;
  assign unused_idx = ^{rs_idx, rt_idx};

  always_comb begin
    hazard     = rs_hit || rt_hit;
    fwd_rs_sel = FWD_RF;
    fwd_rt_sel = FWD_RF;
  end
`endif

  assign dec_ready = !hazard;
  assign issue     = dec_valid && dec_ready;

  always_comb begin
    entries_next = '0;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      entries_next[i] = entries[i-1];
    end
    entries_next[0].valid = issue && reg_write && (wd != REG_ZERO);
    entries_next[0].wd    = wd;
    if (flush) begin
      entries_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else begin
      entries <= entries_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
    end else if (dec_valid && !dec_ready) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (DEPTH=3); expectations follow ISSUE_SB_FWD_EN.
module tb_issue_scoreboard;

`ifdef ISSUE_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  rs, rt, wd;
  logic        require_rs, require_rt, reg_write, flush;
  logic [2:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cycles;

  int passed = 0;
  int total  = 0;
  int exp_stall = 0;

  issue_scoreboard #(.DEPTH(3), .REG_AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .rs           (rs),
    .require_rs   (require_rs),
    .rt           (rt),
    .require_rt   (require_rt),
    .wd           (wd),
    .reg_write    (reg_write),
    .flush        (flush),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic       rrs;
    logic [4:0] rt;
    logic       rrt;
    logic [4:0] wd;
    logic       rw;
    logic       rdy_nf;
    logic       rdy_f;
    logic [2:0] rs_sel_f;
    logic [2:0] rt_sel_f;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] a_rs, input logic a_rrs,
                       input logic [4:0] a_rt, input logic a_rrt,
                       input logic [4:0] a_wd, input logic a_rw);
    dec_valid  = v;
    rs         = a_rs;
    require_rs = a_rrs;
    rt         = a_rt;
    require_rt = a_rrt;
    wd         = a_wd;
    reg_write  = a_rw;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Holds the presented instruction until it issues; reports stalls and selects at issue.
  task automatic wait_issue(output int stalls, output logic [2:0] rs_sel,
                            output logic [2:0] rt_sel, output bit ok);
    stalls = 0;
    ok     = 1'b0;
    rs_sel = 3'd0;
    rt_sel = 3'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dec_ready) begin
        ok     = 1'b1;
        rs_sel = fwd_rs_sel;
        rt_sel = fwd_rt_sel;
        break;
      end
      stalls++;
      next_cycle();
    end
    if (ok) next_cycle();
  endtask

  initial begin
    int         st;
    logic [2:0] s_rs, s_rt;
    bit         ok;

    vecs[0]  = '{1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[1]  = '{1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[2]  = '{1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[3]  = '{1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[4]  = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[5]  = '{1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 5'd8, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[6]  = '{1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[7]  = '{1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[8]  = '{1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[9]  = '{1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2};
    vecs[10] = '{1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0};
    vecs[11] = '{1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0};

    // Reset state
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("reset_ready", 32'(dec_ready), 32'd1);
    check("reset_rs_sel", 32'(fwd_rs_sel), 32'd0);
    check("reset_stall", stall_cycles, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Table of one-cycle vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rrs, vecs[i].rt, vecs[i].rrt, vecs[i].wd, vecs[i].rw);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(dec_ready), 32'(FWD ? vecs[i].rdy_f : vecs[i].rdy_nf));
      check($sformatf("vec%0d_rs_sel", i), 32'(fwd_rs_sel), 32'(FWD ? vecs[i].rs_sel_f : 3'd0));
      check($sformatf("vec%0d_rt_sel", i), 32'(fwd_rt_sel), 32'(FWD ? vecs[i].rt_sel_f : 3'd0));
      next_cycle();
    end
    check("table_stall_count", stall_cycles, 32'(exp_stall));
    idle(3);

    // Back-to-back dependency
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    next_cycle();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    wait_issue(st, s_rs, s_rt, ok);
    check("b2b_issued", 32'(ok), 32'd1);
    check("b2b_stalls", 32'(st), FWD ? 32'd1 : 32'd2);
    check("b2b_rs_sel", 32'(s_rs), FWD ? 32'd2 : 32'd0);
    exp_stall += FWD ? 1 : 2;
    check("b2b_stall_count", stall_cycles, 32'(exp_stall));
    idle(3);

    // One independent instruction between producer and consumer
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    next_cycle();
    drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    next_cycle();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    wait_issue(st, s_rs, s_rt, ok);
    check("gap_issued", 32'(ok), 32'd1);
    check("gap_stalls", 32'(st), FWD ? 32'd0 : 32'd1);
    check("gap_rs_sel", 32'(s_rs), FWD ? 32'd2 : 32'd0);
    exp_stall += FWD ? 0 : 1;
    check("gap_stall_count", stall_cycles, 32'(exp_stall));
    idle(3);

    // Two producers of r7; consumer reads r7 through rt and must pick the younger
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    next_cycle();
    next_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    wait_issue(st, s_rs, s_rt, ok);
    check("dup_issued", 32'(ok), 32'd1);
    check("dup_stalls", 32'(st), FWD ? 32'd1 : 32'd2);
    check("dup_rt_sel", 32'(s_rt), FWD ? 32'd2 : 32'd0);
    check("dup_rs_sel", 32'(s_rs), 32'd0);
    exp_stall += FWD ? 1 : 2;
    check("dup_stall_count", stall_cycles, 32'(exp_stall));
    idle(3);

    // Flush while stalled
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    next_cycle();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("flush_pre_ready", 32'(dec_ready), 32'd0);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    exp_stall += 1;
    @(negedge clk);
    check("flush_post_ready", 32'(dec_ready), 32'd1);
    check("flush_post_rs_sel", 32'(fwd_rs_sel), 32'd0);
    check("flush_stall_count", stall_cycles, 32'(exp_stall));
    next_cycle();

    // Flush drops an instruction issuing in the same cycle
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("flush_drop_ready", 32'(dec_ready), 32'd1);
    check("flush_drop_rs_sel", 32'(fwd_rs_sel), 32'd0);
    next_cycle();
    idle(3);

    // Reset asserted mid-stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    next_cycle();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("rst_pre_ready", 32'(dec_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(dec_ready), 32'd1);
    check("rst_mid_stall", stall_cycles, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-dependency scoreboard that sits immediately after the instruction decoder and consumes its operand/destination fields (`rs`, `require_rs`, `rt`, `require_rt`, `wd`, `reg_write`). It tracks in-flight register writes through the DEPTH-stage back end and holds issue while a required source register has a pending, not-yet-readable write. It returns a ready handshake to the decode stage and, when compiled in, forwarding selects to the operand muxes.

## Interface
- `DEPTH`, 3, number of back-end stages tracked (EX..WB); legal range 2..8.
- `REG_AW`, 5, register address width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decoder presents an instruction.
- `dec_ready`  out  1  scoreboard accepts it this cycle; combinational.
- `rs`, `rt`  in  REG_AW  source register addresses.
- `require_rs`, `require_rt`  in  1  source actually read.
- `wd`  in  REG_AW  destination register.
- `reg_write`  in  1  instruction writes `wd`.
- `flush`  in  1  kill every tracked entry.
- `fwd_rs_sel`, `fwd_rt_sel`  out  3  forwarding source. 0 selects the register file; k selects back-end stage k-1.
- `stall_cycles`  out  32  count of cycles with `dec_valid && !dec_ready`.

## Operation
- State: DEPTH entries {valid, wd}, where entry 0 is the youngest (EX) and entry DEPTH-1 is WB.
- The register file writes at the end of the WB cycle and is write-through, so a match in entry DEPTH-1 is never a hazard.
- Pending write: an entry with valid=1 and wd≠0. An issue with `reg_write=0` or `wd=0` enters as valid=0.
- Operand match (rs, and rt independently): the operand is required, its address is ≠0, and some pending entry i ≤ DEPTH-2 has an equal wd. When several entries match, the lowest i (youngest) wins.
- Hazard without forwarding: any operand match in entries 0..DEPTH-2.
- `dec_ready = !hazard`. It does not depend on `dec_valid`.
- Every cycle the entries shift by one (i → i+1, with DEPTH-1 discarded). Entry 0 loads the issuing instruction on `dec_valid && dec_ready`; otherwise it loads a bubble (valid=0).
- `flush` clears all entries to valid=0 at the edge and also drops any instruction issuing that cycle. Flush dominates issue.
- `stall_cycles` increments on every stalled cycle and wraps from 2^32-1 to 0. `flush` does not clear it.
- Without `ISSUE_SB_FWD_EN`, both forwarding selects are constant 0.

## Timing
- Reset (async assert, sync to clk on release): all entries valid=0, `stall_cycles`=0, `dec_ready`=1, `fwd_*_sel`=0.
- Reset asserted mid-stall clears the hazard immediately, so `dec_ready` rises combinationally.
- Back-to-back dependency without forwarding: the consumer stalls DEPTH-1 cycles. With DEPTH=3 that is 2 stall cycles, and the consumer issues when the producer reaches WB.
- Independent instructions issue one per cycle with zero bubbles.
- Decoder fields are sampled only when `dec_valid`=1, and must remain stable while stalled.

## Configuration
- `ISSUE_SB_FWD_EN` defined:
  - A hazard is raised only for a match in entry 0 (result not yet produced).
  - For matches in entries 1..DEPTH-2, `fwd_*_sel` = i+1 for the youngest matching entry, and issue proceeds. A match only in DEPTH-1 gives 0.
  - Selects are valid whenever `dec_valid && dec_ready`.
- `ISSUE_SB_FWD_EN` undefined: the behaviour under Operation applies, and the selects are tied to 0.

## Structure
- Shared package `arch_pkg`:
  - `sb_entry_t` packed struct {valid, wd}.
  - `REG_ZERO` constant.
  - `FWD_RF` constant (0).
- One sub-module, `sb_match`: one operand's address/require against the entry array, returning the match flag and youngest index. It is instantiated twice, for rs and rt.

## Test plan
- Reset then `dec_valid`=1, rs=1 require_rs=1 → `dec_ready`=1, fwd selects 0, `stall_cycles`=0.
- Issue `wd`=5 `reg_write`=1, next cycle rs=5 require_rs=1, DEPTH=3, no FWD → `dec_ready`=0 for 2 cycles, then 1; `stall_cycles`=2.
- Same sequence with FWD defined → 1 stall cycle; on issue `fwd_rs_sel`=2 (stage 1). With one independent instruction in between → no stall, `fwd_rs_sel`=2.
- Producer `wd`=0 `reg_write`=1, consumer rs=0 require_rs=1, or consumer rt=5 require_rt=0 → no stall.
- Two producers writing 7 in consecutive cycles, consumer reads 7 with FWD → stall on entry 0 first; after one stall, select points at the younger producer (entry 1, sel=2), not the older.
- Stall pending on rs=5, assert `flush` for one cycle → `dec_ready`=1 the next cycle, all entries invalid. Assert `rst_n`=0 mid-stall → `dec_ready`=1 immediately.
